// File: rtl/rscan_pkg.sv
// Shared types and width helpers for the register-file scan checker.
package rscan_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SCAN, ST_REPORT} rscan_state_t;

  // Index width for n entries (at least one bit) and count width for 0..n.
  function automatic int rscan_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rscan_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regfile_scan_checker_halt_detector.sv
// Decides when the monitored core has stopped: explicit halt, PC stuck
// for HALT_STABLE cycles, or TIMEOUT RUN cycles elapsed.
module halt_detector #(
  parameter int AW          = 8,
  parameter int TIMEOUT     = 50,
  parameter int HALT_STABLE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          run,
  input  logic          halt,
  input  logic [AW-1:0] pc_addr,
  output logic          halt_hit,
  output logic          timeout_hit
);

  localparam int RW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(HALT_STABLE + 1);

  logic [RW-1:0] run_cnt;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [AW-1:0] pc_prev;

  // The current cycle counts toward the stable run, saturating at the threshold.
  always_comb begin
    stable_nxt = '0;
    if (pc_addr == pc_prev)
      stable_nxt = (stable_cnt == SW'(HALT_STABLE)) ? stable_cnt : stable_cnt + 1'b1;
  end

  assign halt_hit    = run && (halt || (stable_nxt == SW'(HALT_STABLE)));
  assign timeout_hit = run && (run_cnt == RW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      stable_cnt <= '0;
      pc_prev    <= '0;
    end else if (clear) begin
      run_cnt    <= '0;
      stable_cnt <= '0;
      pc_prev    <= pc_addr;
    end else if (run) begin
      run_cnt    <= run_cnt + 1'b1;
      stable_cnt <= stable_nxt;
      pc_prev    <= pc_addr;
    end
  end

endmodule

// File: rtl/regfile_scan_checker.sv
// Run-and-check monitor: waits for the core to halt, then scans the register
// file one entry per cycle against expected values and reports a verdict.
module regfile_scan_checker
  import rscan_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NREG         = 32,
  parameter int AW           = 8,
  parameter int TIMEOUT      = 50,
  parameter int HALT_STABLE  = 4,
  parameter int REQUIRE_HALT = 0,
  parameter int IW           = rscan_iw(NREG),
  parameter int CW           = rscan_cw(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  input  logic [AW-1:0]   pc_addr,
  output logic [IW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic [IW-1:0]   exp_addr,
  input  logic [XLEN-1:0] exp_data,
  input  logic [NREG-1:0] mask,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   match_cnt,
  output logic            err_valid,
  output logic [IW-1:0]   first_err_idx,
  output logic            timed_out
);

  rscan_state_t state_q, state_d;
  logic [IW-1:0] idx_q;
  logic pass_q, start_ok, halt_hit, timeout_hit, run_exit, last_idx, hit, pass_calc;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign run_exit = halt_hit || timeout_hit;
  assign last_idx = (idx_q == IW'(NREG - 1));
  assign hit      = !mask[idx_q] || (rd_data == exp_data);
  assign pass_calc = (match_cnt == CW'(NREG)) && !((REQUIRE_HALT != 0) && timed_out);

  halt_detector #(.AW(AW), .TIMEOUT(TIMEOUT), .HALT_STABLE(HALT_STABLE)) u_halt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_ok),
    .run         (state_q == ST_RUN),
    .halt        (halt),
    .pc_addr     (pc_addr),
    .halt_hit    (halt_hit),
    .timeout_hit (timeout_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_RUN;
      ST_RUN:    if (run_exit) state_d = ST_SCAN;
      ST_SCAN:   if (last_idx) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      match_cnt     <= '0;
      err_valid     <= 1'b0;
      first_err_idx <= '0;
      timed_out     <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          match_cnt     <= '0;
          err_valid     <= 1'b0;
          first_err_idx <= '0;
          timed_out     <= 1'b0;
          pass_q        <= 1'b0;
        end
        ST_RUN: if (run_exit) begin
          idx_q <= '0;
          // A real halt wins over a coincident timeout.
          if (timeout_hit && !halt_hit) timed_out <= 1'b1;
        end
        ST_SCAN: begin
          if (hit) match_cnt <= match_cnt + 1'b1;
          else if (!err_valid) begin
            err_valid     <= 1'b1;
            first_err_idx <= idx_q;
          end
          if (!last_idx) idx_q <= idx_q + 1'b1;
        end
        ST_REPORT: pass_q <= pass_calc;
        default: ;
      endcase
    end
  end

  // The verdict is visible in the REPORT cycle itself, then held.
  assign pass     = (state_q == ST_REPORT) ? pass_calc : pass_q;
  assign done     = (state_q == ST_REPORT);
  assign busy     = (state_q != ST_IDLE);
  assign rd_addr  = idx_q;
  assign exp_addr = idx_q;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Randomized scoreboard bench for regfile_scan_checker with a behavioural model.
module tb_regfile_scan_checker;
  localparam int XLEN = 64, NREG = 32, AW = 8, TMO = 50, HS = 4, IW = 5, CW = 6;

  typedef struct {
    int unsigned   done_cyc;
    logic [CW-1:0] mc;
    logic          ev;
    logic [IW-1:0] fe;
    logic          to;
    logic          ps;
    logic          ps_rh;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt = 1'b0;
  logic [AW-1:0] pc_addr = '0;
  logic [NREG-1:0] mask = '1;
  logic [IW-1:0] rd_addr, exp_addr, rd_addr2, exp_addr2, first_err_idx, first_err_idx2;
  logic [XLEN-1:0] rd_data, exp_data, rd_data2, exp_data2;
  logic busy, done, pass, err_valid, timed_out, busy2, done2, pass2, err_valid2, timed_out2;
  logic [CW-1:0] match_cnt, match_cnt2;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] ex [NREG];

  assign rd_data   = rf[rd_addr];
  assign exp_data  = ex[exp_addr];
  assign rd_data2  = rf[rd_addr2];
  assign exp_data2 = ex[exp_addr2];

  regfile_scan_checker #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .TIMEOUT(TMO),
                         .HALT_STABLE(HS), .REQUIRE_HALT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .pc_addr(pc_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .exp_addr(exp_addr), .exp_data(exp_data),
    .mask(mask), .busy(busy), .done(done), .pass(pass), .match_cnt(match_cnt),
    .err_valid(err_valid), .first_err_idx(first_err_idx), .timed_out(timed_out));

  regfile_scan_checker #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .TIMEOUT(TMO),
                         .HALT_STABLE(HS), .REQUIRE_HALT(1)) u_dut_rh (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .pc_addr(pc_addr),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .exp_addr(exp_addr2), .exp_data(exp_data2),
    .mask(mask), .busy(busy2), .done(done2), .pass(pass2), .match_cnt(match_cnt2),
    .err_valid(err_valid2), .first_err_idx(first_err_idx2), .timed_out(timed_out2));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  exp_t e_mon;
  bit hold_pend = 1'b0;
  always @(negedge clk) begin
    if (hold_pend) begin
      chk("hold_match_cnt", 64'(match_cnt), 64'(e_mon.mc));
      chk("hold_pass", 64'(pass), 64'(e_mon.ps));
      hold_pend = 1'b0;
    end
    if (rst_n && (done || done2)) begin
      chk("done_pair", 64'(done2), 64'(done));
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done: got done at cycle %0d, required none", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e_mon.done_cyc));
        chk("match_cnt", 64'(match_cnt), 64'(e_mon.mc));
        chk("err_valid", 64'(err_valid), 64'(e_mon.ev));
        chk("first_err_idx", 64'(first_err_idx), 64'(e_mon.fe));
        chk("timed_out", 64'(timed_out), 64'(e_mon.to));
        chk("pass", 64'(pass), 64'(e_mon.ps));
        chk("pass_require_halt", 64'(pass2), 64'(e_mon.ps_rh));
        chk("last_scan_addr", 64'({rd_addr, exp_addr}), 64'({5'd31, 5'd31}));
        hold_pend = 1'b1;
      end
    end
  end

  logic [AW-1:0] pc0;
  logic [AW-1:0] pc_seq [1:TMO];
  bit halt_seq [1:TMO];
  int start_again = 0;

  task automatic fill_regs(input int ndiff);
    for (int i = 0; i < NREG; i++) begin
      rf[i] = {$urandom, $urandom};
      ex[i] = rf[i];
    end
    repeat (ndiff) ex[$urandom_range(0, NREG-1)] ^= (64'd1 << $urandom_range(0, 63));
  endtask

  task automatic pc_inc();
    pc0 = AW'($urandom);
    for (int k = 1; k <= TMO; k++) pc_seq[k] = pc0 + AW'(4 * k);
  endtask

  task automatic clear_halt();
    for (int k = 1; k <= TMO; k++) halt_seq[k] = 1'b0;
  endtask

  logic [25:0] zero_vec;
  assign zero_vec = {busy, done, pass, match_cnt, err_valid, first_err_idx, timed_out, rd_addr, exp_addr};

  // Model the run from the per-cycle PC/halt schedule, then drive it.
  task automatic run_case(input bit push, input int rst_idx);
    int exit_k, run_len;
    bit to, rdone;
    logic [AW-1:0] prev;
    int mism[$];
    exp_t e;
    exit_k = TMO; to = 1'b1; run_len = 0; prev = pc0;
    for (int k = 1; k <= TMO; k++) begin
      run_len = (pc_seq[k] == prev) ? run_len + 1 : 0;
      prev = pc_seq[k];
      if (halt_seq[k] || run_len >= HS) begin exit_k = k; to = 1'b0; break; end
    end
    for (int i = 0; i < NREG; i++) if (mask[i] && rf[i] != ex[i]) mism.push_back(i);
    e.mc    = CW'(NREG - mism.size());
    e.ev    = (mism.size() > 0);
    e.fe    = (mism.size() > 0) ? IW'(mism[0]) : '0;
    e.to    = to;
    e.ps    = (mism.size() == 0);
    e.ps_rh = e.ps && !to;

    @(negedge clk);
    start = 1'b1; halt = 1'b0; pc_addr = pc0;
    e.done_cyc = cyc + exit_k + NREG + 1;
    if (push) sb.push_back(e);
    rdone = 1'b0;
    for (int c = 1; c <= TMO && !rdone; c++) begin
      @(negedge clk);
      if (rst_idx >= 0 && busy && rd_addr == IW'(rst_idx)) begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0;
        @(negedge clk);
        chk("reset_midscan", 64'(zero_vec), 64'd0);
        chk("reset_midscan_rh", 64'({busy2, done2, pass2, match_cnt2, err_valid2}), 64'd0);
        rst_n = 1'b1;
        rdone = 1'b1;
      end else begin
        start = (c == start_again);
        pc_addr = pc_seq[c];
        halt = halt_seq[c];
      end
    end
    @(negedge clk);
    start = 1'b0; halt = 1'b0;
    for (int w = 0; w < 200 && busy; w++) @(negedge clk);
    chk("return_to_idle", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) begin rf[i] = '0; ex[i] = '0; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(zero_vec), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all equal, halt in RUN cycle 10
    fill_regs(0); mask = '1; pc_inc(); clear_halt(); halt_seq[10] = 1'b1;
    run_case(1'b1, -1);
    // regs 5 and 17 differ
    fill_regs(0); ex[5] ^= 64'h8000_0000_0000_0000; ex[17] ^= 64'h1;
    run_case(1'b1, -1);
    // same differences, masked off
    mask[5] = 1'b0; mask[17] = 1'b0;
    run_case(1'b1, -1);
    // PC frozen at 0x20 from cycle 3
    mask = '1; fill_regs(0); clear_halt(); pc0 = '0;
    for (int k = 1; k <= TMO; k++) pc_seq[k] = (k < 3) ? AW'(4 * k) : 8'h20;
    run_case(1'b1, -1);
    // PC never settles: timeout
    fill_regs(0); pc_inc();
    run_case(1'b1, -1);
    // reset in the middle of the scan
    fill_regs(2); ex[3] ^= 64'h10; clear_halt(); halt_seq[2] = 1'b1; pc_inc();
    run_case(1'b0, 10);
    // start during RUN is ignored
    fill_regs(1); clear_halt(); halt_seq[20] = 1'b1; pc_inc(); start_again = 5;
    run_case(1'b1, -1);
    start_again = 0;

    repeat (12) begin
      fill_regs($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) mask = '1;
      else mask = $urandom | $urandom;
      if ($urandom_range(0, 1) != 0) pc_inc();
      else begin
        pc0 = AW'($urandom_range(0, 2));
        for (int k = 1; k <= TMO; k++) pc_seq[k] = AW'($urandom_range(0, 2));
      end
      clear_halt();
      if ($urandom_range(0, 2) == 0) halt_seq[$urandom_range(1, TMO)] = 1'b1;
      run_case(1'b1, -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scan_checker.md
# regfile_scan_checker

Synthesizable run-and-check monitor for the RV64 core, replacing fixed-delay register dumps in benches. On `start` it watches the core until halt (explicit `halt`, stable PC, or timeout). It then scans the DUT register file one entry per cycle against an expected-value memory and reports match count, first mismatch, timeout and pass/fail. It sits beside `riscv_top`, on the register-file debug read port and an expected-value ROM.

## Interface
- `XLEN`, 64: register data width
- `NREG`, 32: number of registers scanned; `IW = $clog2(NREG)`, `CW = $clog2(NREG+1)`
- `AW`, 8: PC / ROM address width
- `TIMEOUT`, 50: max RUN cycles before forced halt
- `HALT_STABLE`, 4: consecutive cycles of unchanged PC that count as halt
- `REQUIRE_HALT`, 0: 1 = a timeout forces `pass=0`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous active-low reset
- `start` in 1: begin monitoring; honoured only in IDLE
- `halt` in 1: explicit core halt (ecall/ebreak decode)
- `pc_addr` in AW: core instruction address (`rom_addr`)
- `rd_addr` out IW: regfile debug read address
- `rd_data` in XLEN: regfile read data, combinational from `rd_addr`
- `exp_addr` out IW: expected-ROM address, always equal to `rd_addr`
- `exp_data` in XLEN: expected value, combinational from `exp_addr`
- `mask` in NREG: bit i = 1 compares reg i; 0 counts reg i as a match
- `busy` out 1: high in RUN, SCAN and REPORT
- `done` out 1: one-cycle pulse in REPORT
- `pass` out 1: final verdict, held until next `start`
- `match_cnt` out CW: matching registers
- `err_valid` out 1: at least one mismatch seen
- `first_err_idx` out IW: lowest mismatching index; valid when `err_valid`
- `timed_out` out 1: RUN ended by TIMEOUT

## Operation
- FSM: IDLE, RUN, SCAN, REPORT.
- IDLE -> RUN on `start`:
  - clear `match_cnt`, `err_valid`, `first_err_idx`, `timed_out`, `pass`
  - capture `pc_addr` as `pc_prev`; zero `run_cnt` and `stable_cnt`
- RUN, each cycle:
  - `run_cnt++`
  - `stable_cnt++` if `pc_addr == pc_prev`, else it clears; `pc_prev <= pc_addr`
- Exit RUN to SCAN, `idx=0`, when any of:
  - `halt` is high
  - `stable_cnt` reaches HALT_STABLE
  - `run_cnt` reaches TIMEOUT-1, i.e. the TIMEOUT-th RUN cycle (also sets `timed_out`)
- Simultaneous exit causes: `timed_out` is set only if no halt/stable cause holds that cycle.
- SCAN, per cycle:
  - `rd_addr = exp_addr = idx`
  - hit = `!mask[idx] || rd_data == exp_data` (full XLEN compare)
  - hit: `match_cnt++`
  - miss with `!err_valid`: set `err_valid`, `first_err_idx = idx`
  - `idx == NREG-1` -> REPORT, else `idx++`
- REPORT, one cycle, then IDLE:
  - `done=1`
  - `pass = (match_cnt == NREG) && !(REQUIRE_HALT && timed_out)`
- x0 is compared like any other register.
- `start` while `busy` is ignored.

## Timing
- Reset values: all outputs 0, `rd_addr = exp_addr = 0`, FSM in IDLE.
- `rst_n` low at any state, including mid-scan, resets everything on the next edge; no partial report.
- `start` sampled at edge 0 -> RUN from cycle 1.
- Exit condition sampled in RUN cycle k -> SCAN occupies cycles k+1 .. k+NREG -> REPORT in cycle k+NREG+1.
- `match_cnt` is final in the REPORT cycle. It and `pass`, `err_valid`, `first_err_idx`, `timed_out` hold until the next accepted `start`.
- Worst-case latency from `start` to `done`: TIMEOUT + NREG + 1 cycles.
- `rd_addr`/`exp_addr` outside SCAN hold the last value driven.

## Structure
- Package `rscan_pkg`: state enum `rscan_state_t`, width helper constants (`IW`, `CW` derivations).
- Sub-module `halt_detector`:
  - owns `run_cnt`, `stable_cnt`, `pc_prev`
  - outputs `halt_hit` and `timeout_hit`
  - parameters AW, TIMEOUT, HALT_STABLE
- Top holds the FSM and the scan/compare datapath.

## Test plan
1. All 32 regs equal, `mask` all ones, `halt` pulsed in RUN cycle 10 -> `done` in cycle 43, `match_cnt=32`, `pass=1`, `err_valid=0`, `timed_out=0`.
2. Reg 5 and reg 17 differ -> `match_cnt=30`, `err_valid=1`, `first_err_idx=5`, `pass=0`.
3. Same as 2 with `mask[5]=0`, `mask[17]=0` -> `match_cnt=32`, `pass=1`.
4. PC frozen at 0x20 from cycle 3, no `halt` -> halt after 4 stable cycles, `timed_out=0`. PC incrementing forever instead -> `timed_out=1` at RUN cycle 50; `pass=1` with REQUIRE_HALT=0, `pass=0` with REQUIRE_HALT=1.
5. `rst_n` low during SCAN at idx 10 -> next cycle all outputs 0 and FSM in IDLE. A `start` pulsed during RUN is ignored and the run completes normally with one `done`.
